// File: rtl/bus_arbiter.sv
// Four-requester round-robin bus arbiter with bounded hold time.
// A grant lasts until the owner releases its request, or until the owner has
// held the bus for MAX_HOLD cycles while someone else is waiting. Every grant
// is followed by a one-cycle GAP with the bus idle before the next grant.
module bus_arbiter #(
  parameter int BUS_WIDTH = 8,
  parameter int MAX_HOLD  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           req,
  input  logic [BUS_WIDTH-1:0] data_in0,
  input  logic [BUS_WIDTH-1:0] data_in1,
  input  logic [BUS_WIDTH-1:0] data_in2,
  input  logic [BUS_WIDTH-1:0] data_in3,
  output logic [3:0]           gnt,
  output logic [1:0]           sel,
  output logic                 bus_valid,
  output logic [BUS_WIDTH-1:0] data_out
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  // Counter value at which the owner may be preempted; the counter stops here.
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  logic [1:0] state_q, state_d;
  logic [1:0] owner_q, owner_d;
  logic [1:0] ptr_q,   ptr_d;
  logic [7:0] cnt_q,   cnt_d;
  logic [3:0] gnt_q,   gnt_d;
  logic [1:0] sel_q,   sel_d;
  logic       vld_q,   vld_d;
  logic       others_waiting;

  // Round-robin pick: first set bit of r starting at index p, wrapping 3->0.
  // Offsets are scanned from farthest to nearest so the nearest one wins.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    logic [1:0] pick;
    pick = p;
    for (int k = 3; k >= 0; k--) begin
      idx = p + 2'(k);
      if (r[idx]) pick = idx;
    end
    return pick;
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  // Next-state logic for the arbitration FSM, pointer and hold counter.
  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    ptr_d          = ptr_q;
    cnt_d          = cnt_q;
    others_waiting = |(req & ~onehot(owner_q));
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          state_d = S_GRANT;
          owner_d = rr_pick(req, ptr_q);
          cnt_d   = 8'd0;
        end
      end
      S_GRANT: begin
        // Release, or preemption once the hold budget is used up; when
        // preempting, the owner's own request no longer matters.
        if (!req[owner_q] || ((cnt_q == HOLD_LAST) && others_waiting)) begin
          state_d = S_GAP;
          ptr_d   = owner_q + 2'd1;
          cnt_d   = 8'd0;
        end else if (cnt_q != HOLD_LAST) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_GAP: begin
        // ptr_q already points past the previous owner here.
        if (|req) begin
          state_d = S_GRANT;
          owner_d = rr_pick(req, ptr_q);
          cnt_d   = 8'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // Grant outputs are registered, derived from the state being entered.
  always_comb begin
    vld_d = (state_d == S_GRANT);
    gnt_d = vld_d ? onehot(owner_d) : 4'b0000;
    sel_d = vld_d ? owner_d : 2'd0;
  end

  // State and output registers; reset wins over every transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      owner_q <= 2'd0;
      ptr_q   <= 2'd0;
      cnt_q   <= 8'd0;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'd0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      vld_q   <= vld_d;
    end
  end

  assign gnt       = gnt_q;
  assign sel       = sel_q;
  assign bus_valid = vld_q;

  // Combinational data mux; the bus reads zero whenever nobody owns it.
  always_comb begin
    data_out = '0;
    if (vld_q) begin
      case (sel_q)
        2'd0:    data_out = data_in0;
        2'd1:    data_out = data_in1;
        2'd2:    data_out = data_in2;
        default: data_out = data_in3;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter (BUS_WIDTH=8, MAX_HOLD=4).
module tb_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [7:0] data_in0, data_in1, data_in2, data_in3;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       bus_valid;
  logic [7:0] data_out;

  int checks   = 0;
  int failures = 0;

  bus_arbiter #(.BUS_WIDTH(8), .MAX_HOLD(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .data_in0  (data_in0),
    .data_in1  (data_in1),
    .data_in2  (data_in2),
    .data_in3  (data_in3),
    .gnt       (gnt),
    .sel       (sel),
    .bus_valid (bus_valid),
    .data_out  (data_out)
  );

  always #5 clk = ~clk;

  // Advance one rising edge; outputs are then observed 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 4'b0000;
    step();
    rst = 1'b0;
  endtask

  // Grant invariants sampled on every falling edge once reset has been applied.
  logic mon_en = 1'b0;
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (bus_valid !== (gnt != 4'b0000) || (bus_valid && gnt !== (4'b0001 << sel))
          || (!bus_valid && sel !== 2'd0)) begin
        failures++;
        $display("FAIL invariant gnt=%b sel=%0d bus_valid=%b", gnt, sel, bus_valid);
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    req = 4'b1111;
    step();
    step();
    mon_en = 1'b1;
    checks++;
    if (gnt !== 4'b0000) begin failures++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
    checks++;
    if (sel !== 2'd0) begin failures++; $display("FAIL reset_sel got=%0d exp=0", sel); end
    checks++;
    if (bus_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus_valid); end
    checks++;
    if (data_out !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", data_out); end
    rst = 1'b0;
    req = 4'b0000;
    step();
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0100;
    step();
    checks++;
    if (gnt !== 4'b0100) begin failures++; $display("FAIL single_gnt got=%b exp=0100", gnt); end
    checks++;
    if (sel !== 2'd2) begin failures++; $display("FAIL single_sel got=%0d exp=2", sel); end
    checks++;
    if (bus_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", bus_valid); end
    checks++;
    if (data_out !== 8'hA5) begin failures++; $display("FAIL single_data got=%h exp=a5", data_out); end
    req = 4'b0000;
    step();
    checks++;
    if (gnt !== 4'b0000 || bus_valid !== 1'b0) begin
      failures++; $display("FAIL single_gap got gnt=%b valid=%b exp gnt=0000 valid=0", gnt, bus_valid);
    end
    step();
    checks++;
    if (gnt !== 4'b0000) begin failures++; $display("FAIL single_idle got=%b exp=0000", gnt); end
  endtask

  task automatic test_round_robin();
    logic [3:0] r;
    logic [3:0] exp_g;
    do_reset();
    r   = 4'b1111;
    req = r;
    for (int i = 0; i < 4; i++) begin
      exp_g = 4'b0001 << i;
      step();
      checks++;
      if (gnt !== exp_g || sel !== 2'(i)) begin
        failures++; $display("FAIL rr_first_%0d got gnt=%b sel=%0d exp gnt=%b sel=%0d", i, gnt, sel, exp_g, i);
      end
      step();
      checks++;
      if (gnt !== exp_g) begin
        failures++; $display("FAIL rr_second_%0d got=%b exp=%b", i, gnt, exp_g);
      end
      r[i] = 1'b0;
      req  = r;
      step();
      checks++;
      if (gnt !== 4'b0000 || data_out !== 8'h00) begin
        failures++; $display("FAIL rr_gap_%0d got gnt=%b data=%h exp gnt=0000 data=00", i, gnt, data_out);
      end
    end
    step();
  endtask

  task automatic test_preempt();
    do_reset();
    req = 4'b0001;
    for (int c = 1; c <= 4; c++) begin
      step();
      checks++;
      if (gnt !== 4'b0001) begin
        failures++; $display("FAIL preempt_hold_%0d got=%b exp=0001", c, gnt);
      end
      if (c == 2) req = 4'b0011;
    end
    step();
    checks++;
    if (gnt !== 4'b0000) begin failures++; $display("FAIL preempt_gap got=%b exp=0000", gnt); end
    step();
    checks++;
    if (gnt !== 4'b0010 || data_out !== 8'h3C) begin
      failures++; $display("FAIL preempt_next got gnt=%b data=%h exp gnt=0010 data=3c", gnt, data_out);
    end
    req = 4'b0001;
    step();
    step();
    checks++;
    if (gnt !== 4'b0001) begin failures++; $display("FAIL preempt_return got=%b exp=0001", gnt); end
    req = 4'b0000;
    step();
    step();
  endtask

  task automatic test_hold_alone();
    int bad;
    do_reset();
    req = 4'b1000;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      checks++;
      if (gnt !== 4'b1000) begin
        failures++; bad++;
        if (bad <= 3) $display("FAIL hold_cycle_%0d got=%b exp=1000", c, gnt);
      end
    end
    // Counter must already sit at its limit: a newcomer preempts at once.
    req = 4'b1001;
    step();
    checks++;
    if (gnt !== 4'b0000) begin failures++; $display("FAIL hold_preempt_gap got=%b exp=0000", gnt); end
    step();
    checks++;
    if (gnt !== 4'b0001 || data_out !== 8'h11) begin
      failures++; $display("FAIL hold_next got gnt=%b data=%h exp gnt=0001 data=11", gnt, data_out);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    req = 4'b0010;
    step();
    checks++;
    if (gnt !== 4'b0010 || data_out !== 8'h3C) begin
      failures++; $display("FAIL b2b_first got gnt=%b data=%h exp gnt=0010 data=3c", gnt, data_out);
    end
    req = 4'b0100;
    step();
    checks++;
    if (gnt !== 4'b0000 || data_out !== 8'h00 || bus_valid !== 1'b0) begin
      failures++; $display("FAIL b2b_gap got gnt=%b data=%h valid=%b exp gnt=0000 data=00 valid=0", gnt, data_out, bus_valid);
    end
    step();
    checks++;
    if (gnt !== 4'b0100 || data_out !== 8'hA5) begin
      failures++; $display("FAIL b2b_second got gnt=%b data=%h exp gnt=0100 data=a5", gnt, data_out);
    end
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    req = 4'b0100;
    step();
    checks++;
    if (gnt !== 4'b0100) begin failures++; $display("FAIL rstmid_grant got=%b exp=0100", gnt); end
    req = 4'b0110;
    rst = 1'b1;
    step();
    checks++;
    if (gnt !== 4'b0000 || bus_valid !== 1'b0) begin
      failures++; $display("FAIL rstmid_drop got gnt=%b valid=%b exp gnt=0000 valid=0", gnt, bus_valid);
    end
    rst = 1'b0;
    step();
    checks++;
    if (gnt !== 4'b0010 || sel !== 2'd1) begin
      failures++; $display("FAIL rstmid_next got gnt=%b sel=%0d exp gnt=0010 sel=1", gnt, sel);
    end
  endtask

  initial begin
    rst      = 1'b1;
    req      = 4'b0000;
    data_in0 = 8'h11;
    data_in1 = 8'h3C;
    data_in2 = 8'hA5;
    data_in3 = 8'h5A;
    test_reset();
    test_single();
    test_round_robin();
    test_preempt();
    test_hold_alone();
    test_back_to_back();
    test_reset_mid_grant();
    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter BUS_WIDTH, default 8; width of each requester data bus and of data_out.
REQ-002 Parameter MAX_HOLD, default 4; maximum consecutive GRANT cycles before preemption when others are waiting; legal range 2..255.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req  input  4  request vector; bit i high = requester i wants the bus, held high for the whole transfer.
REQ-006 data_in0..data_in3  input  BUS_WIDTH each  requester data buses.
REQ-007 gnt  output  4  registered one-hot grant; all-zero when no owner.
REQ-008 sel  output  2  registered binary index of granted requester; mux4 select encoding, LSB = index bit 0.
REQ-009 bus_valid  output  1  registered; high exactly when gnt is non-zero.
REQ-010 data_out  output  BUS_WIDTH  combinational; data_in[sel] while bus_valid, else all-zero.

Function
REQ-011 FSM states: IDLE, GRANT, GAP; encoded in 2 bits, no other reachable state.
REQ-012 IDLE: gnt=0; if req!=0 at an edge, next state GRANT with owner = winner.
REQ-013 Winner = first set bit of req scanning from index ptr upward, wrapping 3->0 (round-robin).
REQ-014 ptr is 2 bits; on leaving GRANT it is set to owner+1 modulo 4.
REQ-015 Grant latency: req sampled high at edge N -> gnt, sel, bus_valid valid after edge N (one cycle).
REQ-016 GRANT: gnt[owner]=1, sel=owner; 8-bit hold counter cleared on entry, incremented each GRANT cycle, saturating at MAX_HOLD-1.
REQ-017 GRANT -> GAP when req[owner] sampled low (release).
REQ-018 GRANT -> GAP when counter = MAX_HOLD-1 and any other req bit is high (preemption); owner's req is ignored at that point.
REQ-019 Counter at MAX_HOLD-1 with no other requester: stay in GRANT, owner keeps bus indefinitely.
REQ-020 GAP: exactly one cycle, gnt=0, bus_valid=0, sel=0; next state GRANT (winner from REQ-013 using updated ptr) if req!=0, else IDLE.
REQ-021 Release and new request on same edge: GAP first, new requester granted on following edge; no back-to-back grant without GAP.
REQ-022 Preempted owner still requesting competes normally after GAP; with updated ptr it has lowest priority.
REQ-023 gnt never has more than one bit set; sel and gnt never disagree while bus_valid=1.
REQ-024 Request bits for non-owners changing during GRANT do not affect the grant except via REQ-018.

Reset
REQ-025 rst sampled high at an edge: state=IDLE, ptr=0, counter=0, gnt=0, sel=0, bus_valid=0, data_out=0 after that edge.
REQ-026 rst high during GRANT drops the grant after that same edge; no GAP cycle is inserted.
REQ-027 rst has priority over every transition; req is ignored while rst is high.
REQ-028 First grant after reset follows REQ-013 with ptr=0.

Verification
REQ-029 Reset, then req=4'b0100 held, data_in2=8'hA5 -> after one edge gnt=4'b0100, sel=2, bus_valid=1, data_out=8'hA5.
REQ-030 req=4'b1111 from reset, each owner drops req after 2 GRANT cycles -> grant order 0,1,2,3, each separated by one gnt=0 cycle.
REQ-031 req0 held forever, req1 raised during its 2nd GRANT cycle, MAX_HOLD=4 -> req0 granted 4 cycles, GAP, then gnt=4'b0010.
REQ-032 req3 held alone for 20 cycles -> gnt=4'b1000 continuously, no GAP, counter saturated at 3.
REQ-033 Owner 1 drops req on the same edge req2 rises -> GAP cycle (gnt=0, data_out=0), then gnt=4'b0100.
REQ-034 rst pulsed for one edge during GRANT of requester 2 -> gnt=0 after that edge; with req=4'b0110 still high, next grant is requester 1 (ptr=0).
